// File: rtl/alu_sched_pkg.sv
// Shared constants and types for the two-requester ALU scheduler.
// Opcode values and widths are fixed by the ALU core.
package alu_sched_pkg;

   localparam int INST_W = 10;
   localparam int DATA_W = 4;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_OR  = 2'b10;
   localparam logic [1:0] OP_NEG = 2'b11;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/alu_sched_alu.sv
// Combinational 4-bit ALU core.
// The instruction is {op[1:0], A[3:0], B[3:0]}. No carry or overflow is produced.
module ALU
   import alu_sched_pkg::*;
(
   input  logic [INST_W-1:0] inst_i,
   output logic [DATA_W-1:0] result_o
);

   logic [1:0]        op;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;

   assign op = inst_i[INST_W-1 -: 2];
   assign a  = inst_i[2*DATA_W-1 -: DATA_W];
   assign b  = inst_i[DATA_W-1:0];

   always_comb begin
      result_o = '0;
      case (op)
         OP_ADD:  result_o = a + b;
         OP_SUB:  result_o = a - b;
         OP_OR:   result_o = a | b;
         default: result_o = ~a + DATA_W'(1);
      endcase
   end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler that time-shares one ALU between two requesters.
// Results go into a one-entry register that supports accept-while-consume.
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [INST_W-1:0] req0_inst,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [INST_W-1:0] req1_inst,
   output logic              req1_ready,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data,
   output logic              res_src,
   output logic              res_zero,
   input  logic              res_ready,
   output logic [CNT_W-1:0]  ops_done
);

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              src_q, src_d;
   logic              zero_q, zero_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              can_accept;
   logic              grant0;
   logic              grant1;
   logic [INST_W-1:0] alu_inst;
   logic [DATA_W-1:0] alu_res;

   ALU u_alu (
      .inst_i   (alu_inst),
      .result_o (alu_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_EMPTY;
         last_grant_q <= 1'b1;
         data_q       <= '0;
         src_q        <= 1'b0;
         zero_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         data_q       <= data_d;
         src_q        <= src_d;
         zero_q       <= zero_d;
         cnt_q        <= cnt_d;
      end
   end

   // rst gates the grants so no handshake can be seen while reset is held.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      data_d       = data_q;
      src_d        = src_q;
      zero_d       = zero_q;
      cnt_d        = cnt_q;

      can_accept = (state_q == ST_EMPTY) || res_ready;
      grant0     = !rst && can_accept && req0_valid && (!req1_valid || last_grant_q);
      grant1     = !rst && can_accept && req1_valid && (!req0_valid || !last_grant_q);
      alu_inst   = grant1 ? req1_inst : req0_inst;

      if (state_q == ST_FULL && res_ready) begin
         cnt_d   = cnt_q + CNT_W'(1);
         state_d = ST_EMPTY;
      end

      if (grant0 || grant1) begin
         state_d      = ST_FULL;
         data_d       = alu_res;
         zero_d       = (alu_res == '0);
         src_d        = grant1;
         last_grant_d = grant1;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign res_valid  = (state_q == ST_FULL);
   assign res_data   = data_q;
   assign res_src    = src_q;
   assign res_zero   = zero_q;
   assign ops_done   = cnt_q;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: randomized and directed stimulus, queue
// scoreboard fed on each handshake and drained by an output monitor.
module tb_alu_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0;
   logic [9:0] req0_inst = '0;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [9:0] req1_inst = '0;
   logic       req1_ready;
   logic       res_valid;
   logic [3:0] res_data;
   logic       res_src;
   logic       res_zero;
   logic       res_ready = 1'b0;
   logic [7:0] ops_done;

   typedef struct {
      logic       src;
      logic [3:0] data;
   } exp_t;

   exp_t       sb_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic       m_last  = 1'b1;
   logic       cur_full = 1'b0;
   logic [7:0] exp_cnt = '0;

   alu_sched dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_inst  (req0_inst),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_inst  (req1_inst),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_src    (res_src),
      .res_zero   (res_zero),
      .res_ready  (res_ready),
      .ops_done   (ops_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference ALU written from the opcode table with plain arithmetic.
   function automatic logic [3:0] alu_ref(input logic [9:0] inst);
      int a, b, r;
      a = int'(inst[7:4]);
      b = int'(inst[3:0]);
      case (inst[9:8])
         2'd0:    r = (a + b) % 16;
         2'd1:    r = (a - b + 16) % 16;
         2'd2:    r = a | b;
         default: r = (16 - a) % 16;
      endcase
      return r[3:0];
   endfunction

   // Output monitor: compares the held result to the scoreboard head, pops on consume.
   always @(negedge clk) begin
      if (!rst) begin
         cur_full = (sb_q.size() != 0);
         check("res_valid", 32'(res_valid), 32'(cur_full));
         check("ops_done", 32'(ops_done), 32'(exp_cnt));
         if (res_valid && cur_full) begin
            check("res_data", 32'(res_data), 32'(sb_q[0].data));
            check("res_src", 32'(res_src), 32'(sb_q[0].src));
            check("res_zero", 32'(res_zero), 32'(sb_q[0].data == 4'd0));
            if (res_ready) begin
               $display("[TB] consume src=%0d data=%0d cnt=%0d", res_src, res_data, exp_cnt);
               void'(sb_q.pop_front());
               exp_cnt = exp_cnt + 8'd1;
            end
         end
      end
   end

   // Grant checker and scoreboard feed, runs after the monitor each cycle.
   always @(negedge clk) begin
      logic can, e0, e1;
      #2;
      if (!rst) begin
         can = !cur_full || res_ready;
         if (req0_valid && req1_valid) begin
            e0 = can && m_last;
            e1 = can && !m_last;
         end else begin
            e0 = can && req0_valid;
            e1 = can && req1_valid;
         end
         check("req0_ready", 32'(req0_ready), 32'(e0));
         check("req1_ready", 32'(req1_ready), 32'(e1));
         if (req0_valid && req0_ready) begin
            sb_q.push_back('{src: 1'b0, data: alu_ref(req0_inst)});
            m_last = 1'b0;
            $display("[TB] issue src=0 inst=%03h exp=%0d", req0_inst, alu_ref(req0_inst));
         end else if (req1_valid && req1_ready) begin
            sb_q.push_back('{src: 1'b1, data: alu_ref(req1_inst)});
            m_last = 1'b1;
            $display("[TB] issue src=1 inst=%03h exp=%0d", req1_inst, alu_ref(req1_inst));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic observe();
      @(negedge clk);
      #3;
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_last  = 1'b1;
      exp_cnt = '0;
   endtask

   task automatic drain();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b1;
      step();
      step();
   endtask

   initial begin
      logic [3:0] held;

      // Reset values and ready suppression while reset is held.
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      res_ready  = 1'b1;
      #3;
      check("rst_ready0", 32'(req0_ready), 0);
      check("rst_ready1", 32'(req1_ready), 0);
      check("rst_valid", 32'(res_valid), 0);
      check("rst_data", 32'(res_data), 0);
      check("rst_src", 32'(res_src), 0);
      check("rst_zero", 32'(res_zero), 0);
      check("rst_cnt", 32'(ops_done), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Contention: grant order 0,1,0,1 after reset.
      req0_inst = {2'b00, 4'd1, 4'd2};
      req1_inst = {2'b10, 4'd4, 4'd1};
      for (int i = 0; i < 4; i++) begin
         observe();
         check("cont_ready0", 32'(req0_ready), 32'(i % 2 == 0));
         check("cont_ready1", 32'(req1_ready), 32'(i % 2 == 1));
         step();
      end
      drain();

      // Basic add from requester 0.
      req0_valid = 1'b1;
      req0_inst  = {2'b00, 4'b0011, 4'b0101};
      res_ready  = 1'b1;
      observe();
      check("add_ready0", 32'(req0_ready), 1);
      step();
      req0_valid = 1'b0;
      observe();
      check("add_data", 32'(res_data), 8);
      check("add_src", 32'(res_src), 0);
      check("add_zero", 32'(res_zero), 0);
      step();
      observe();
      check("add_cnt", 32'(ops_done), 5);
      step();

      // Negate zero, then subtract, from requester 1.
      req1_valid = 1'b1;
      req1_inst  = {2'b11, 4'b0000, 4'b1010};
      step();
      req1_inst  = {2'b01, 4'b0010, 4'b0101};
      observe();
      check("neg_data", 32'(res_data), 0);
      check("neg_zero", 32'(res_zero), 1);
      check("neg_src", 32'(res_src), 1);
      step();
      req1_valid = 1'b0;
      observe();
      check("sub_data", 32'(res_data), 13);
      step();
      drain();

      // Backpressure: hold FULL with both requesters valid.
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_inst  = {2'b10, 4'd9, 4'd6};
      req1_inst  = {2'b00, 4'd7, 4'd7};
      res_ready  = 1'b0;
      observe();
      check("bp_first0", 32'(req0_ready), 1);
      step();
      observe();
      held = res_data;
      for (int i = 0; i < 3; i++) begin
         step();
         observe();
         check("bp_ready0", 32'(req0_ready), 0);
         check("bp_ready1", 32'(req1_ready), 0);
         check("bp_hold", 32'(res_data), 32'(held));
      end
      step();
      res_ready = 1'b1;
      observe();
      check("bp_next1", 32'(req1_ready), 1);
      check("bp_next0", 32'(req0_ready), 0);
      step();

      // Asynchronous reset while FULL.
      res_ready = 1'b0;
      observe();
      check("ar_full", 32'(res_valid), 1);
      step();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("ar_valid", 32'(res_valid), 0);
      check("ar_ready0", 32'(req0_ready), 0);
      check("ar_ready1", 32'(req1_ready), 0);
      check("ar_cnt", 32'(ops_done), 0);
      step();
      rst = 1'b0;
      res_ready = 1'b1;
      observe();
      check("ar_first0", 32'(req0_ready), 1);
      step();
      drain();

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         req0_valid = 1'($urandom_range(0, 1));
         req1_valid = 1'($urandom_range(0, 1));
         req0_inst  = 10'($urandom);
         req1_inst  = 10'($urandom);
         res_ready  = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();

      // Counter wrap: 256 consumes from a fresh reset, last result left unconsumed.
      rst = 1'b1;
      model_reset();
      step();
      rst = 1'b0;
      req0_valid = 1'b1;
      res_ready  = 1'b1;
      for (int i = 0; i < 257; i++) begin
         req0_inst = 10'($urandom);
         step();
      end
      req0_valid = 1'b0;
      res_ready  = 1'b0;
      observe();
      check("wrap_cnt", 32'(ops_done), 0);
      check("wrap_full", 32'(res_valid), 1);
      step();
      drain();
      observe();
      check("wrap_after", 32'(ops_done), 1);
      check("sb_empty", 32'(sb_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-requester scheduler that time-shares one combinational 4-bit ALU core (`ALU`, 10-bit instruction `{op[1:0], A[3:0], B[3:0]}`).
- Arbitrates round-robin between two instruction sources using valid/ready handshakes.
- Issues the granted instruction to the ALU and captures the result in a one-entry output register, tagged with source and a zero flag.
- Counts completed operations.
- Sits between the instruction front-ends (GUI/test drivers) and any result consumer.

## Interface
Parameters:
- `INST_W`, 10, instruction width; fixed by the ALU core.
- `DATA_W`, 4, result width; fixed by the ALU core.
- `CNT_W`, 8, width of the completed-operation counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0_valid`  in  1  requester 0 has an instruction.
- `req0_inst`  in  10  requester 0 instruction `{op, A, B}`.
- `req0_ready`  out  1  requester 0 instruction accepted this cycle.
- `req1_valid`, `req1_inst`, `req1_ready`: same as the requester 0 ports, for requester 1.
- `res_valid`  out  1  result register holds data.
- `res_data`  out  4  ALU result.
- `res_src`  out  1  requester that issued the held result.
- `res_zero`  out  1  1 when `res_data` == 0.
- `res_ready`  in  1  consumer takes the result this cycle.
- `ops_done`  out  CNT_W  completed (consumed) operations, wraps modulo 2^CNT_W.

## Operation
- State machine on the result register:
  - EMPTY (`res_valid`=0): can accept.
  - FULL (`res_valid`=1).
- `can_accept` = EMPTY, or FULL with `res_ready`=1. This gives a pass-through pipeline at one op per cycle.
- Arbitration, when `can_accept`:
  - Only one requester valid: grant it.
  - Both valid: grant the requester not granted last (`last_grant` register).
  - Not `can_accept`: no grant.
- `reqN_ready` = grant N. It is combinational from `req0_valid`, `req1_valid`, state and `res_ready`. At most one `ready` is high per cycle. `ready` is never high while that requester's `valid` is low.
- On a handshake (`reqN_valid` & `reqN_ready`):
  - The granted instruction is muxed into the ALU.
  - `res_data`, `res_zero` and `res_src`=N are registered.
  - `last_grant` is set to N.
  - State goes to FULL.
- `res_ready` in FULL with no new grant → EMPTY. Output data holds its last value and is don't-care.
- `ops_done` increments on each `res_valid` & `res_ready`. It wraps from 255 to 0.
- ALU arithmetic is the core's:
  - 00: A+B mod 16.
  - 01: A−B mod 16.
  - 10: A|B.
  - 11: (~A+1) mod 16.
  - No carry or overflow is exported.
- While FULL and `res_ready`=0: `res_*` are held stable and both `ready` are 0.
- Reset mid-operation: the held result is discarded with no count and no handshake. The requesters must re-present their instructions.

## Timing
- Reset values:
  - `res_valid`=0, `res_data`=0, `res_src`=0, `res_zero`=0, `ops_done`=0.
  - `last_grant`=1, so requester 0 wins the first contention.
  - Both `ready`=0 while `rst` is asserted.
- Latency: instruction accepted at edge k → result visible on `res_*` after edge k, held until consumed.
- Throughput: one instruction per cycle when `res_ready` is held at 1.
- Simultaneous consume and accept at the same edge: the new result replaces the old one, state stays FULL, and `ops_done` increments by 1.
- No combinational path from `res_ready` to `res_*`. A path from `res_ready` to `reqN_ready` exists and is required.

## Structure
- Package `alu_sched_pkg`:
  - Opcode constants `OP_ADD`=2'b00, `OP_SUB`=2'b01, `OP_OR`=2'b10, `OP_NEG`=2'b11.
  - `INST_W`, `DATA_W`.
  - State encoding EMPTY/FULL.
- Sub-module: one instance of the existing `ALU` core, driven by the grant mux. No other sub-modules; the arbiter is inline.

## Test plan
- Basic add: `req0_inst`={00,0011,0101}, `res_ready`=1 → next cycle `res_data`=1000, `res_src`=0, `res_zero`=0, then `ops_done`=1.
- Negate zero: `req1_inst`={11,0000,xxxx} → `res_data`=0000, `res_zero`=1, `res_src`=1. Then subtract {01,0010,0101} → `res_data`=1101.
- Contention: both valid continuously for 4 cycles, `res_ready`=1 → grant order 0,1,0,1. Each `ready` is high exactly 2 cycles, and one result is delivered per cycle.
- Backpressure:
  - Set `res_ready`=0 with the result FULL and both valid for 3 cycles → `res_*` stable and both `ready`=0.
  - Raise `res_ready` → the next grant goes to the requester not last served.
- Counter wrap: 256 consumed ops → `ops_done` returns to 0. A FULL, unconsumed result is not counted.
- Async reset: assert `rst` mid-cycle while FULL → `res_valid` drops immediately, with no edge needed. After release, first contention grants requester 0.
